// File: rtl/mult_result_fifo.sv
// Result FIFO between a pipelined multiplier and its sink: first-word-fall-through,
// valid/ready on both sides, no bypass from in_data to out_data.
module mult_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Handshake flags come from count alone, so neither side sees a combinational
  // path from the other; a full FIFO therefore pops first and accepts next cycle.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage is not reset; stale entries are never visible because out_valid gates them.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_mult_result_fifo.sv
// Directed vector table plus hand sequences and a queue-model random run for mult_result_fifo.
module tb_mult_result_fifo;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  mult_result_fifo #(.DATA_W(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ov;
    logic [31:0] od;
    logic        ir;
    logic [2:0]  cnt;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic ov, input logic [31:0] od,
                             input logic ir, input logic [2:0] cnt);
    check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    check({tag, " in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    check({tag, " count"},     {29'd0, count},     {29'd0, cnt});
    if (ov) check({tag, " out_data"}, out_data, od);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] model [$];
  logic        r_iv, r_or, do_push, do_pop;
  logic [31:0] r_d;

  initial begin
    // in_valid, in_data, out_ready | out_valid, out_data, in_ready, count (before the edge)
    vecs[0]  = '{1'b1, 32'h6,  1'b0, 1'b0, 32'h0,  1'b1, 3'd0};
    vecs[1]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h6,  1'b1, 3'd1};
    vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h6,  1'b1, 3'd1};
    vecs[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h6,  1'b1, 3'd1};
    vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h6,  1'b1, 3'd1};
    vecs[5]  = '{1'b1, 32'h11, 1'b0, 1'b0, 32'h0,  1'b1, 3'd0};
    vecs[6]  = '{1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b1, 3'd1};
    vecs[7]  = '{1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 1'b1, 3'd2};
    vecs[8]  = '{1'b1, 32'h44, 1'b0, 1'b1, 32'h11, 1'b1, 3'd3};
    vecs[9]  = '{1'b1, 32'h55, 1'b0, 1'b1, 32'h11, 1'b0, 3'd4};
    vecs[10] = '{1'b1, 32'h55, 1'b0, 1'b1, 32'h11, 1'b0, 3'd4};
    vecs[11] = '{1'b1, 32'h55, 1'b1, 1'b1, 32'h11, 1'b0, 3'd4};
    vecs[12] = '{1'b1, 32'h55, 1'b1, 1'b1, 32'h22, 1'b1, 3'd3};
    vecs[13] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h33, 1'b1, 3'd3};
    vecs[14] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h44, 1'b1, 3'd2};
    vecs[15] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h55, 1'b1, 3'd1};
    vecs[16] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 3'd0};
    vecs[17] = '{1'b1, 32'hA5, 1'b1, 1'b0, 32'h0,  1'b1, 3'd0};
    vecs[18] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'hA5, 1'b1, 3'd1};
    vecs[19] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA5, 1'b1, 3'd1};
    vecs[20] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 3'd0};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_state("reset_async", 1'b0, 32'h0, 1'b1, 3'd0);
    @(posedge clk);
    #6 rst = 1'b0;
    step();
    check_state("after_reset", 1'b0, 32'h0, 1'b1, 3'd0);

    for (int i = 0; i < NVEC; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].ir, vecs[i].cnt);
      step();
    end

    // streaming: one transfer per cycle, pointers wrap three times
    for (int i = 1; i <= 12; i++) begin
      in_valid = 1'b1; in_data = 32'(i); out_ready = 1'b1;
      #1;
      if (i == 1) check_state($sformatf("stream%0d", i), 1'b0, 32'h0, 1'b1, 3'd0);
      else        check_state($sformatf("stream%0d", i), 1'b1, 32'(i - 1), 1'b1, 3'd1);
      step();
    end
    in_valid = 1'b0;
    #1 check_state("stream_last", 1'b1, 32'd12, 1'b1, 3'd1);
    step();
    check_state("stream_drained", 1'b0, 32'h0, 1'b1, 3'd0);

    // mid-operation reset at occupancy 3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h70 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    #1 check_state("pre_rst", 1'b1, 32'h70, 1'b1, 3'd3);
    rst = 1'b1;
    #1 check_state("rst_pulse", 1'b0, 32'h0, 1'b1, 3'd0);
    #4 rst = 1'b0;
    step();
    check_state("post_rst", 1'b0, 32'h0, 1'b1, 3'd0);
    in_valid = 1'b1; in_data = 32'h99;
    step();
    in_valid = 1'b0;
    #1 check_state("post_rst_push", 1'b1, 32'h99, 1'b1, 3'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1 check_state("post_rst_empty", 1'b0, 32'h0, 1'b1, 3'd0);

    // random traffic against a reference queue
    model.delete();
    for (int c = 0; c < 2000; c++) begin
      r_iv = 1'($urandom_range(0, 1));
      r_or = 1'($urandom_range(0, 1));
      r_d  = $urandom;
      in_valid = r_iv; in_data = r_d; out_ready = r_or;
      #1;
      check_state("rand", (model.size() != 0),
                  (model.size() != 0) ? model[0] : 32'h0,
                  (model.size() != 4), 3'(model.size()));
      do_push = r_iv && (model.size() != 4);
      do_pop  = r_or && (model.size() != 0);
      step();
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back(r_d);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_result_fifo.md
MULT_RESULT_FIFO -- requirements
Module: mult_result_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the product width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; legal values are powers of 2 with DEPTH >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream multiplier presents a product (driven from its dest_valid).
REQ-006 The block SHALL have port in_data, input, DATA_W bits: the product from the multiplier.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the FIFO can accept a product (drives the multiplier's dest_ready).
REQ-008 The block SHALL have port out_valid, output, 1 bit: the head entry is valid to the sink.
REQ-009 The block SHALL have port out_data, output, DATA_W bits: the head entry.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the sink accepts the head entry.
REQ-011 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the current occupancy, 0..DEPTH.

Function
REQ-012 A push SHALL occur on a rising edge where in_valid && in_ready; in_data is written at the write pointer, and the write pointer advances by 1 modulo DEPTH.
REQ-013 A pop SHALL occur on a rising edge where out_valid && out_ready; the read pointer advances by 1 modulo DEPTH.
REQ-014 in_ready SHALL equal (count != DEPTH), be derived from registered state only, and have no combinational dependence on out_ready or in_valid.
REQ-015 out_valid SHALL equal (count != 0), be derived from registered state only, and have no combinational dependence on in_valid.
REQ-016 out_data SHALL equal storage[read pointer] whenever out_valid=1, in first-word-fall-through fashion; its value when out_valid=0 is don't-care.
REQ-017 There SHALL be no bypass path: a product pushed on edge N is first visible on out_valid/out_data after edge N, never in the same cycle.
REQ-018 count SHALL update per edge as: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-019 When full (count=DEPTH), a simultaneous out_ready SHALL pop only; in_ready stays 0 in that cycle, and the push is accepted no earlier than the following cycle.
REQ-020 When empty (count=0), in_valid SHALL push only; out_ready is ignored.
REQ-021 When 0<count<DEPTH and both handshakes are active, the block SHALL perform push and pop in the same edge, sustaining 1 transfer/cycle.
REQ-022 Entries SHALL emerge in strict push order; no data loss or duplication across pointer wrap-around.
REQ-023 While in_ready=0, in_data and in_valid SHALL be ignored (the upstream holds dest_valid until accepted, per its protocol).
REQ-024 out_data of the head entry SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Occupancy SHALL be tracked with pointers plus count, or with (log2(DEPTH)+1)-bit pointers; either way, full and empty SHALL be unambiguous at DEPTH entries.

Reset
REQ-026 While rst=1, both pointers and count SHALL be cleared to 0 immediately, without waiting for a clk edge.
REQ-027 During and directly after reset, the outputs SHALL be out_valid=0, in_ready=1, count=0; storage contents are not reset and are don't-care.
REQ-028 Reset asserted mid-operation, at any occupancy, SHALL discard all entries; the first push after rst deasserts is the first entry popped.
REQ-029 rst deassertion SHALL be synchronous to clk for the purposes of the bench (deasserted away from the clk edge); no handshake is accepted on an edge while rst=1.

Verification
REQ-030 The bench SHALL cover: reset, then push 0x0000_0006 with out_ready=0 -> the next cycle shows out_valid=1, out_data=0x0000_0006, count=1; the value holds for 3 cycles.
REQ-031 The bench SHALL cover: push 4 products (0x11, 0x22, 0x33, 0x44) with out_ready=0 -> count=4, in_ready=0; a fifth in_valid with 0x55 held is not accepted until a pop occurs.
REQ-032 The bench SHALL cover: full with out_ready=1 and in_valid=1 -> the first edge pops 0x11 only (count=3); the next edge pushes 0x55 and pops 0x22 (count stays 3).
REQ-033 The bench SHALL cover: 12 back-to-back pushes 1..12 with out_ready=1 continuously -> one transfer/cycle after the first, output 1..12 in order, pointers wrap 3 times, count never exceeds 1.
REQ-034 The bench SHALL cover: count=3, then rst pulsed high for half a clk period -> out_valid=0, count=0, in_ready=1 immediately; after a subsequent push of 0x99, out_data=0x99.
REQ-035 The bench SHALL cover: random in_valid/out_ready at 50% each for 2000 cycles against a reference queue model -> no ordering or data mismatch, count equal to model occupancy every cycle.
